// File: rtl/sink_list_purge_pkg.sv
// Shared definitions for the sink-list purge block and its helpers.
//   - memory word / address widths and table dimensions
//   - address map of neighborCount, sinkIDs[][] and sinkIDCount[]
//   - purge FSM state encoding
//   - address helpers for a sinkIDs entry and a sinkIDCount row
package sink_list_purge_pkg;

  localparam int WORD_WIDTH    = 16;
  localparam int ADDR_WIDTH    = 11;
  localparam int MAX_NEIGHBORS = 64;
  localparam int MAX_SINKS     = 8;
  localparam int NUM_REMOVE    = 4;

  localparam logic [ADDR_WIDTH-1:0] NBR_COUNT_ADDR = 11'h68A;
  localparam logic [ADDR_WIDTH-1:0] SINKIDS_BASE   = 11'h248;
  localparam logic [ADDR_WIDTH-1:0] SCOUNT_BASE    = 11'h68E;

  // Counters must be able to hold the clamped maximum itself, hence +1.
  localparam int ROW_W = $clog2(MAX_NEIGHBORS + 1);
  localparam int PTR_W = $clog2(MAX_SINKS + 1);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RD_NCNT = 4'd1,
    ST_LD_NCNT = 4'd2,
    ST_RD_SCNT = 4'd3,
    ST_LD_SCNT = 4'd4,
    ST_RD_ENT  = 4'd5,
    ST_LD_ENT  = 4'd6,
    ST_WR_ENT  = 4'd7,
    ST_WR_SCNT = 4'd8,
    ST_FIN     = 4'd9
  } state_e;

  // Byte address of sinkIDs[row][slot]; two bytes per word.
  function automatic logic [ADDR_WIDTH-1:0] entry_addr(input logic [ROW_W-1:0] row,
                                                       input logic [PTR_W-1:0] slot);
    return SINKIDS_BASE +
           ((ADDR_WIDTH'(row) * ADDR_WIDTH'(MAX_SINKS) + ADDR_WIDTH'(slot)) << 1);
  endfunction

  // Byte address of sinkIDCount[row].
  function automatic logic [ADDR_WIDTH-1:0] scount_addr(input logic [ROW_W-1:0] row);
    return SCOUNT_BASE + (ADDR_WIDTH'(row) << 1);
  endfunction

endpackage

// File: rtl/sink_list_purge_match.sv
// sink_id_match: combinational N-way compare of one ID against a set of
// removal IDs, each gated by its own valid bit.
//   id_i            ID under test
//   remove_ids_i    packed removal IDs, channel k at [k*ID_W +: ID_W]
//   remove_valid_i  per-channel enable
//   hit_o           1 when id_i equals any enabled channel
module sink_id_match
  import sink_list_purge_pkg::*;
#(
  parameter int N_IDS = NUM_REMOVE,
  parameter int ID_W  = WORD_WIDTH
) (
  input  logic [ID_W-1:0]       id_i,
  input  logic [N_IDS*ID_W-1:0] remove_ids_i,
  input  logic [N_IDS-1:0]      remove_valid_i,
  output logic                  hit_o
);

  always_comb begin
    hit_o = 1'b0;
    for (int k = 0; k < N_IDS; k++) begin
      if (remove_valid_i[k] && (remove_ids_i[k*ID_W +: ID_W] == id_i)) begin
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sink_list_purge.sv
// sink_list_purge: after the destination check, walks every neighbour's
// sinkIDs row, deletes entries matching the latched removal IDs, compacts the
// row in place and rewrites its sinkIDCount when anything was removed.
//   clock, nrst            clock / async active-low reset
//   en, done_iamDestination start pulse and its qualifier
//   remove_ids/_valid      removal IDs, sampled only at start
//   address, wr_en,        shared memory port (1-cycle read latency)
//   mem_data_out/_in
//   busy, done             run status
//   removed_count          entries deleted this run (saturating)
//
// state      | meaning
// -----------+-----------------------------------------------
// IDLE       | waiting for a qualified start
// RD_NCNT    | address = neighborCount
// LD_NCNT    | capture/clamp neighborCount
// RD_SCNT    | address = sinkIDCount[row]
// LD_SCNT    | capture/clamp row length, reset rp/wp
// RD_ENT     | address = sinkIDs[row][rp]
// LD_ENT     | capture entry, match against removal IDs
// WR_ENT     | move surviving entry down to slot wp
// WR_SCNT    | write compacted length wp to sinkIDCount[row]
// FIN        | drop busy, raise done
module sink_list_purge
  import sink_list_purge_pkg::*;
(
  input  logic                             clock,
  input  logic                             nrst,
  input  logic                             en,
  input  logic                             done_iamDestination,
  input  logic [NUM_REMOVE*WORD_WIDTH-1:0] remove_ids,
  input  logic [NUM_REMOVE-1:0]            remove_valid,
  output logic [ADDR_WIDTH-1:0]            address,
  output logic                             wr_en,
  input  logic [WORD_WIDTH-1:0]            mem_data_out,
  output logic [WORD_WIDTH-1:0]            mem_data_in,
  output logic                             busy,
  output logic [ADDR_WIDTH-1:0]            removed_count,
  output logic                             done
);

  state_e                           state_q, state_d;
  logic [ROW_W-1:0]                 ncnt_q, ncnt_d;
  logic [ROW_W-1:0]                 row_q, row_d;
  logic [PTR_W-1:0]                 scnt_q, scnt_d;
  logic [PTR_W-1:0]                 rp_q, rp_d;
  logic [PTR_W-1:0]                 wp_q, wp_d;
  logic                             row_hit_q, row_hit_d;
  logic [WORD_WIDTH-1:0]            entry_q, entry_d;
  logic [NUM_REMOVE*WORD_WIDTH-1:0] ids_q, ids_d;
  logic [NUM_REMOVE-1:0]            valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]            removed_q, removed_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic [ADDR_WIDTH-1:0]            address_q, address_d;
  logic                             wr_en_q, wr_en_d;
  logic [WORD_WIDTH-1:0]            wdata_q, wdata_d;

  logic hit;
  logic end_row;
  logic next_row;

  sink_id_match #(
    .N_IDS (NUM_REMOVE),
    .ID_W  (WORD_WIDTH)
  ) u_match (
    .id_i           (mem_data_out),
    .remove_ids_i   (ids_q),
    .remove_valid_i (valid_q),
    .hit_o          (hit)
  );

  always_comb begin
    state_d   = state_q;
    ncnt_d    = ncnt_q;
    row_d     = row_q;
    scnt_d    = scnt_q;
    rp_d      = rp_q;
    wp_d      = wp_q;
    row_hit_d = row_hit_q;
    entry_d   = entry_q;
    ids_d     = ids_q;
    valid_d   = valid_q;
    removed_d = removed_q;
    busy_d    = busy_q;
    done_d    = done_q;
    address_d = address_q;
    wr_en_d   = 1'b0;
    wdata_d   = wdata_q;
    end_row   = 1'b0;
    next_row  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en && done_iamDestination) begin
          ids_d     = remove_ids;
          valid_d   = remove_valid;
          removed_d = '0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_RD_NCNT;
        end
      end
      ST_RD_NCNT: state_d = ST_LD_NCNT;
      ST_LD_NCNT: begin
        if (mem_data_out > WORD_WIDTH'(MAX_NEIGHBORS)) ncnt_d = ROW_W'(MAX_NEIGHBORS);
        else                                           ncnt_d = mem_data_out[ROW_W-1:0];
        row_d = '0;
        if (ncnt_d == '0) state_d = ST_FIN;
        else              state_d = ST_RD_SCNT;
      end
      ST_RD_SCNT: state_d = ST_LD_SCNT;
      ST_LD_SCNT: begin
        if (mem_data_out > WORD_WIDTH'(MAX_SINKS)) scnt_d = PTR_W'(MAX_SINKS);
        else                                       scnt_d = mem_data_out[PTR_W-1:0];
        rp_d      = '0;
        wp_d      = '0;
        row_hit_d = 1'b0;
        if (scnt_d == '0) next_row = 1'b1;
        else              state_d  = ST_RD_ENT;
      end
      ST_RD_ENT: state_d = ST_LD_ENT;
      ST_LD_ENT: begin
        entry_d = mem_data_out;
        rp_d    = rp_q + PTR_W'(1);
        if (hit) begin
          if (removed_q != '1) removed_d = removed_q + ADDR_WIDTH'(1);
          row_hit_d = 1'b1;
        end else if (wp_q != rp_q) begin
          state_d = ST_WR_ENT;
        end else begin
          // Nothing removed yet in this row: entry is already in place.
          wp_d = wp_q + PTR_W'(1);
        end
        if (state_d != ST_WR_ENT) begin
          if (rp_d == scnt_q) end_row = 1'b1;
          else                state_d = ST_RD_ENT;
        end
      end
      ST_WR_ENT: begin
        wp_d = wp_q + PTR_W'(1);
        if (rp_q == scnt_q) end_row = 1'b1;
        else                state_d = ST_RD_ENT;
      end
      ST_WR_SCNT: next_row = 1'b1;
      ST_FIN:     state_d  = ST_IDLE;
      default:    state_d  = ST_IDLE;
    endcase

    if (end_row) begin
      if (row_hit_d) state_d  = ST_WR_SCNT;
      else           next_row = 1'b1;
    end

    if (next_row) begin
      if ((row_q + ROW_W'(1)) == ncnt_q) begin
        state_d = ST_FIN;
      end else begin
        row_d   = row_q + ROW_W'(1);
        state_d = ST_RD_SCNT;
      end
    end

    // Port outputs are registered and set up for the state being entered,
    // so address/data are stable for the whole cycle of that state.
    case (state_d)
      ST_RD_NCNT: address_d = NBR_COUNT_ADDR;
      ST_RD_SCNT: address_d = scount_addr(row_d);
      ST_RD_ENT:  address_d = entry_addr(row_d, rp_d);
      ST_WR_ENT: begin
        address_d = entry_addr(row_d, wp_d);
        wdata_d   = entry_d;
        wr_en_d   = 1'b1;
      end
      ST_WR_SCNT: begin
        address_d = scount_addr(row_d);
        wdata_d   = WORD_WIDTH'(wp_d);
        wr_en_d   = 1'b1;
      end
      ST_FIN: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      ncnt_q    <= '0;
      row_q     <= '0;
      scnt_q    <= '0;
      rp_q      <= '0;
      wp_q      <= '0;
      row_hit_q <= 1'b0;
      entry_q   <= '0;
      ids_q     <= '0;
      valid_q   <= '0;
      removed_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      address_q <= '0;
      wr_en_q   <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ncnt_q    <= ncnt_d;
      row_q     <= row_d;
      scnt_q    <= scnt_d;
      rp_q      <= rp_d;
      wp_q      <= wp_d;
      row_hit_q <= row_hit_d;
      entry_q   <= entry_d;
      ids_q     <= ids_d;
      valid_q   <= valid_d;
      removed_q <= removed_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      address_q <= address_d;
      wr_en_q   <= wr_en_d;
      wdata_q   <= wdata_d;
    end
  end

  assign address       = address_q;
  assign wr_en         = wr_en_q;
  assign mem_data_in   = wdata_q;
  assign busy          = busy_q;
  assign removed_count = removed_q;
  assign done          = done_q;

endmodule

// File: tb/tb_sink_list_purge.sv
module tb_sink_list_purge;

  localparam logic [10:0] NBR_A   = 11'h68A;
  localparam int          BASE_A  = 'h248;
  localparam int          SCNT_A  = 'h68E;

  typedef struct {
    logic [10:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clock;
  logic        nrst;
  logic        en;
  logic        done_iam;
  logic [63:0] remove_ids;
  logic [3:0]  remove_valid;
  logic [10:0] address;
  logic        wr_en;
  logic [15:0] mem_data_out;
  logic [15:0] mem_data_in;
  logic        busy;
  logic [10:0] removed_count;
  logic        done;

  logic [15:0] mem [1024];
  logic [15:0] ref_mem [1024];
  logic        bd_we;
  logic [10:0] bd_addr;
  logic [15:0] bd_data;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  sink_list_purge dut (
    .clock               (clock),
    .nrst                (nrst),
    .en                  (en),
    .done_iamDestination (done_iam),
    .remove_ids          (remove_ids),
    .remove_valid        (remove_valid),
    .address             (address),
    .wr_en               (wr_en),
    .mem_data_out        (mem_data_out),
    .mem_data_in         (mem_data_in),
    .busy                (busy),
    .removed_count       (removed_count),
    .done                (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared memory: synchronous read, data valid one cycle after address.
  always @(posedge clock) begin
    if (bd_we)      mem[bd_addr[10:1]] <= bd_data;
    else if (wr_en) mem[address[10:1]] <= mem_data_in;
    mem_data_out <= mem[address[10:1]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mem_put(input int a, input logic [15:0] d);
    @(negedge clock);
    bd_we   = 1'b1;
    bd_addr = 11'(a);
    bd_data = d;
    ref_mem[a >> 1] = d;
    @(negedge clock);
    bd_we = 1'b0;
  endtask

  task automatic put_row(input int n, input int cnt, input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2, input logic [15:0] e3);
    mem_put(SCNT_A + 2*n, 16'(cnt));
    mem_put(BASE_A + 2*(n*8 + 0), e0);
    mem_put(BASE_A + 2*(n*8 + 1), e1);
    mem_put(BASE_A + 2*(n*8 + 2), e2);
    mem_put(BASE_A + 2*(n*8 + 3), e3);
  endtask

  // Reference purge over ref_mem: pushes every expected write in order.
  task automatic model_run(input logic [63:0] ids, input logic [3:0] vld,
                           output int rem, output int cyc);
    int nc, sc, w, writes;
    logic [15:0] v;
    bit hit;
    rem = 0;
    cyc = 3;
    nc  = int'(ref_mem[NBR_A >> 1]);
    if (nc > 64) nc = 64;
    for (int n = 0; n < nc; n++) begin
      sc = int'(ref_mem[(SCNT_A + 2*n) >> 1]);
      if (sc > 8) sc = 8;
      w = 0;
      writes = 0;
      for (int j = 0; j < sc; j++) begin
        v = ref_mem[(BASE_A + 2*(n*8 + j)) >> 1];
        hit = 1'b0;
        for (int k = 0; k < 4; k++)
          if (vld[k] && ids[k*16 +: 16] == v) hit = 1'b1;
        if (hit) begin
          rem++;
        end else begin
          if (w != j) begin
            exp_q.push_back('{a: 11'(BASE_A + 2*(n*8 + w)), d: v});
            ref_mem[(BASE_A + 2*(n*8 + w)) >> 1] = v;
            writes++;
          end
          w++;
        end
      end
      if (w != sc) begin
        exp_q.push_back('{a: 11'(SCNT_A + 2*n), d: 16'(w)});
        ref_mem[(SCNT_A + 2*n) >> 1] = 16'(w);
        writes++;
      end
      cyc += 2 + 2*sc + writes;
    end
  endtask

  task automatic run_case(input string tag, input logic [63:0] ids, input logic [3:0] vld,
                          input bit poke_en, output int wr_cnt, output logic [10:0] max_a);
    int  rem, cyc, t, busy_cyc;
    wr_t e;
    model_run(ids, vld, rem, cyc);
    @(negedge clock);
    remove_ids   = ids;
    remove_valid = vld;
    done_iam     = 1'b1;
    en           = 1'b1;
    t = 0; busy_cyc = 0; wr_cnt = 0; max_a = '0;
    do begin
      @(negedge clock);
      t++;
      en = poke_en && (t == 4);
      if (t == 1) begin
        // Inputs change after the start; the run must not pick them up.
        remove_ids   = ~ids;
        remove_valid = ~vld;
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        chk({tag, "_done_start"}, 32'(done), 32'd0);
      end
      if (busy) begin
        busy_cyc++;
        if (address > max_a) max_a = address;
      end
      if (wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk({tag, "_wr_unexpected"}, 32'(address), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_wr_addr"}, 32'(address), 32'(e.a));
          chk({tag, "_wr_data"}, 32'(mem_data_in), 32'(e.d));
        end
      end
    end while (done !== 1'b1 && t < 20000);
    en = 1'b0;
    chk({tag, "_timeout"}, 32'(t < 20000), 32'd1);
    chk({tag, "_removed"}, 32'(removed_count), 32'(rem));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_missing_wr"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_cycle_bound"}, 32'(busy_cyc + 1 <= cyc), 32'd1);
    exp_q.delete();
    @(negedge clock);
  endtask

  task automatic image_chk(input string tag);
    int diff;
    diff = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk({tag, "_mem_image"}, 32'(diff), 32'd0);
  endtask

  initial begin
    int          wc, t;
    logic [10:0] ma;
    nrst = 1'b0; en = 1'b0; done_iam = 1'b0;
    remove_ids = '0; remove_valid = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (3) @(negedge clock);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wdata", 32'(mem_data_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_removed", 32'(removed_count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    nrst = 1'b1;

    for (int i = 0; i < 1024; i++) mem_put(2*i, 16'd0);

    // Duplicates of a removed ID, survivors keep order.
    mem_put(NBR_A, 16'd2);
    put_row(0, 4, 16'd5, 16'd9, 16'd5, 16'd7);
    put_row(1, 2, 16'd1, 16'd2, 16'd0, 16'd0);
    run_case("dup", {48'd0, 16'd5}, 4'b0001, 1'b0, wc, ma);
    chk("dup_row0_e0", 32'(mem[(BASE_A >> 1) + 0]), 32'd9);
    chk("dup_row0_e1", 32'(mem[(BASE_A >> 1) + 1]), 32'd7);
    chk("dup_row0_cnt", 32'(mem[SCNT_A >> 1]), 32'd2);
    chk("dup_done", 32'(done), 32'd1);
    image_chk("dup");

    // Start without the qualifier is ignored.
    @(negedge clock);
    done_iam = 1'b0; en = 1'b1;
    @(negedge clock);
    en = 1'b0;
    repeat (3) @(negedge clock);
    chk("noqual_busy", 32'(busy), 32'd0);
    chk("noqual_done", 32'(done), 32'd1);

    // Two channels, invalid channel holding a present ID, en re-pulsed mid-run.
    put_row(0, 3, 16'd1, 16'd2, 16'd9, 16'd0);
    put_row(1, 3, 16'd3, 16'd7, 16'd3, 16'd0);
    run_case("two_ch", {16'd0, 16'd7, 16'd3, 16'd9}, 4'b0110, 1'b1, wc, ma);
    chk("two_ch_row1_cnt", 32'(mem[(SCNT_A >> 1) + 1]), 32'd0);
    chk("two_ch_row0_cnt", 32'(mem[SCNT_A >> 1]), 32'd3);
    image_chk("two_ch");

    // Clamping of both counts on a full table.
    mem_put(NBR_A, 16'd200);
    for (int n = 0; n < 64; n++) begin
      mem_put(SCNT_A + 2*n, 16'd12);
      for (int j = 0; j < 8; j++) mem_put(BASE_A + 2*(n*8 + j), 16'(1 + $urandom_range(0, 5)));
    end
    run_case("clamp", {16'd4, 32'd0, 16'd2}, 4'b1001, 1'b0, wc, ma);
    chk("clamp_max_addr", 32'(ma <= 11'h70D), 32'd1);
    chk("clamp_last_row", 32'(ma), 32'h70C);
    image_chk("clamp");

    // No valid channels: full walk, no writes.
    run_case("novalid", {16'd3, 16'd3, 16'd5, 16'd6}, 4'b0000, 1'b0, wc, ma);
    chk("novalid_writes", 32'(wc), 32'd0);
    chk("novalid_done", 32'(done), 32'd1);

    // Reset while row 3 is being processed.
    mem_put(NBR_A, 16'd8);
    @(negedge clock);
    remove_ids = {48'd0, 16'd1}; remove_valid = 4'b0001; done_iam = 1'b1; en = 1'b1;
    @(negedge clock);
    en = 1'b0;
    t = 0;
    while (!(busy && address == 11'(SCNT_A + 6)) && t < 2000) begin
      @(negedge clock);
      t++;
    end
    chk("rstmid_reach_row3", 32'(t < 2000), 32'd1);
    nrst = 1'b0;
    #1;
    chk("rstmid_address", 32'(address), 32'd0);
    chk("rstmid_wr_en", 32'(wr_en), 32'd0);
    chk("rstmid_wdata", 32'(mem_data_in), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_removed", 32'(removed_count), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    wc = 0;
    repeat (3) begin @(negedge clock); if (wr_en) wc++; end
    nrst = 1'b1;
    repeat (6) begin @(negedge clock); if (wr_en) wc++; end
    chk("rstmid_no_writes", 32'(wc), 32'd0);
    chk("rstmid_idle_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
